frame_counter: RTL and testbench
================================

# frame_counter

APU frame sequencer driving the channel envelope, length and sweep units. Counts `apu_clk` cycles, emits registered one-cycle `qtr_clk` and `hlf_clk` pulses at the quarter-frame and half-frame points, and raises the frame IRQ in 4-step mode. Sits directly upstream of every `pulse` channel instance, whose `qtr_clk`/`hlf_clk` inputs it drives. Configured by writes to the frame-counter register ($4017).

## Interface
- `STEP1`, default 3728: count value of quarter-frame event 1.
- `STEP2`, default 7456: count value of event 2 (quarter + half).
- `STEP3`, default 11185: count value of event 3 (quarter).
- `STEP4`, default 14914: 4-step final event (quarter + half + IRQ); wrap point in 4-step mode.
- `STEP5`, default 18640: 5-step final event (quarter + half); wrap point in 5-step mode.
- `CNT_W`, default 15: counter width; must satisfy `2**CNT_W > STEP5`.

Ports:
- `apu_clk` in 1: the block's single clock.
- `rst` in 1: reset, synchronous and active-high.
- `wr_en` in 1: one-cycle write strobe for $4017.
- `wr_data` in 8: write data; bit 7 = mode (0 = 4-step, 1 = 5-step), bit 6 = IRQ inhibit; other bits ignored.
- `irq_clr` in 1: one-cycle clear of the frame IRQ flag (status read of $4015).
- `qtr_clk` out 1: quarter-frame pulse, registered, one cycle wide.
- `hlf_clk` out 1: half-frame pulse, registered, one cycle wide.
- `irq` out 1: frame IRQ flag, level.

## Operation
- State: `cnt` (CNT_W bits), `mode`, `inhibit`, `irq`.
- Every cycle without a write, `cnt` advances by 1, except at the wrap point:
  - 4-step mode wraps STEP4 → 0 (period STEP4+1).
  - 5-step mode wraps STEP5 → 0 (period STEP5+1).
- 4-step decode:
  - `cnt`==STEP1 or STEP3 → quarter.
  - `cnt`==STEP2 or STEP4 → quarter + half.
  - `cnt`==STEP4 with `inhibit`=0 → set `irq`.
- 5-step decode:
  - `cnt`==STEP1 or STEP3 → quarter.
  - `cnt`==STEP2 or STEP5 → quarter + half.
  - `cnt`==STEP4 → nothing.
  - IRQ is never set.
- Write (`wr_en`=1):
  - Latch `mode` and `inhibit`; `cnt` goes to 0.
  - If the new mode is 5-step, issue an immediate quarter + half.
  - If the new inhibit is 1, clear `irq`.
  - The decode of the current `cnt` in the write cycle is suppressed.
- `irq_clr` clears `irq`.
  - Set and clear in the same cycle: set wins.
  - Write with inhibit=1 in the same cycle as an IRQ set point: the write wins (the set is suppressed and `irq` is cleared).
- `hlf_clk` is never asserted without `qtr_clk` in the same cycle.

## Timing
- Reset values: `cnt`=0, `mode`=0 (4-step), `inhibit`=0, `irq`=0, `qtr_clk`=0, `hlf_clk`=0.
- Reset takes priority over `wr_en` and `irq_clr`. Reset mid-frame discards the count; no pulse is emitted in the reset cycle or the cycle after it.
- Latency: decode at `cnt`==X in cycle N gives `qtr_clk`/`hlf_clk` high in cycle N+1 only. `irq` rises in cycle N+1.
- Write in cycle N:
  - `cnt`=0 in cycle N+1.
  - With 5-step mode, `qtr_clk`=`hlf_clk`=1 in cycle N+1.
  - The first regular quarter follows STEP1 cycles after `cnt` reaches 0.
- `irq_clr` in cycle N gives `irq`=0 in cycle N+1.
- Back-to-back writes: each restarts the count. A pulse pair appears after every 5-step write.
- A mode change by write never leaves `cnt` beyond the new wrap point, because `cnt` restarts at 0.

## Structure
- Shared package `apu_pkg` holds:
  - the step constants (STEP1–STEP5 defaults);
  - the mode encoding (`MODE_4STEP`=0, `MODE_5STEP`=1);
  - the $4017 bit positions (mode = 7, inhibit = 6), shared with the register-decode block.
- One flat module with no sub-module: a counter, a combinational step decode, and registered pulse/IRQ outputs.
- For simulation, benches may override STEP1–STEP5 with small values; behaviour must remain identical when scaled.

## Test plan
- Reset, then free run in 4-step mode with defaults → `qtr_clk` at cycles 3729, 7457, 11186, 14915; `hlf_clk` at 7457 and 14915; `irq` rises at cycle 14915; period 14915.
- Write 0x80 → next cycle both pulses high. Then quarters at +3728, +7456, +11185, +18640 from the counter-zero cycle, halves at +7456 and +18640. `irq` stays 0 over two frames.
- 4-step mode with `irq` set, write 0x40 → `irq` 0 next cycle and stays 0 across subsequent STEP4 hits. A later write of 0x00 plus `irq_clr` leaves `irq` at 0 until the next STEP4.
- `irq_clr` asserted in the exact decode cycle of STEP4 → `irq`=1 afterwards (set wins). `irq_clr` one cycle later → `irq`=0.
- Write 0x00 at `cnt`==STEP2 (4-step) → no `qtr_clk`/`hlf_clk` in the following cycle, and the next quarter comes STEP1 cycles after the counter restart.
- Assert `rst` for one cycle at `cnt`==STEP1-1 in 5-step mode → no pulse. Afterwards: 4-step mode, `irq`=0, first quarter 3728 cycles after the counter restart.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU definitions: frame-sequencer step points, mode encoding and
// the $4017 register bit positions used by the frame counter and register decode.
package apu_pkg;

  localparam int STEP1_DEF = 3728;
  localparam int STEP2_DEF = 7456;
  localparam int STEP3_DEF = 11185;
  localparam int STEP4_DEF = 14914;
  localparam int STEP5_DEF = 18640;
  localparam int CNT_W_DEF = 15;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } mode_e;

  localparam int REG4017_MODE_BIT    = 7;
  localparam int REG4017_INHIBIT_BIT = 6;

endpackage

// File: rtl/frame_counter.sv
// APU frame sequencer: counts apu_clk cycles and emits registered quarter/half
// frame pulses plus the 4-step frame IRQ, reconfigured by $4017 writes.
module frame_counter
  import apu_pkg::*;
#(
  parameter int STEP1 = STEP1_DEF,
  parameter int STEP2 = STEP2_DEF,
  parameter int STEP3 = STEP3_DEF,
  parameter int STEP4 = STEP4_DEF,
  parameter int STEP5 = STEP5_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       apu_clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       irq_clr,
  output logic       qtr_clk,
  output logic       hlf_clk,
  output logic       irq
);

  localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);

  logic [CNT_W-1:0] cnt;
  mode_e            mode;
  logic             inhibit;

  logic [CNT_W-1:0] wrap_pt;
  logic             dec_qtr;
  logic             dec_hlf;
  logic             dec_irq;

  logic             new_5step;
  logic             new_inhibit;
  logic             unused_wr_bits;

  assign new_5step      = wr_data[REG4017_MODE_BIT];
  assign new_inhibit    = wr_data[REG4017_INHIBIT_BIT];
  assign unused_wr_bits = ^wr_data[5:0];

  // The final event doubles as the wrap point, so one compare serves both.
  always_comb begin
    wrap_pt = S4;
    dec_qtr = 1'b0;
    dec_hlf = 1'b0;
    dec_irq = 1'b0;
    if (mode == MODE_5STEP) begin
      wrap_pt = S5;
    end
    if (cnt == S1 || cnt == S3) begin
      dec_qtr = 1'b1;
    end
    if (cnt == S2 || cnt == wrap_pt) begin
      dec_qtr = 1'b1;
      dec_hlf = 1'b1;
    end
    if (mode == MODE_4STEP && cnt == S4 && !inhibit) begin
      dec_irq = 1'b1;
    end
  end

  // A write overrides the decode of the current count; an IRQ set beats irq_clr.
  always_ff @(posedge apu_clk) begin
    if (rst) begin
      cnt     <= '0;
      mode    <= MODE_4STEP;
      inhibit <= 1'b0;
      irq     <= 1'b0;
      qtr_clk <= 1'b0;
      hlf_clk <= 1'b0;
    end else if (wr_en) begin
      cnt     <= '0;
      mode    <= mode_e'(new_5step);
      inhibit <= new_inhibit;
      qtr_clk <= new_5step;
      hlf_clk <= new_5step;
      if (new_inhibit || irq_clr) begin
        irq <= 1'b0;
      end
    end else begin
      cnt     <= (cnt == wrap_pt) ? '0 : cnt + 1'b1;
      qtr_clk <= dec_qtr;
      hlf_clk <= dec_hlf;
      if (dec_irq) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_counter.sv
// Bench for frame_counter with scaled step points: directed vector table plus
// randomized traffic, every cycle checked against a frame-schedule model.
module tb_frame_counter;

  localparam int S1 = 4;
  localparam int S2 = 8;
  localparam int S3 = 12;
  localparam int S4 = 16;
  localparam int S5 = 20;

  logic       apu_clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       irq_clr;
  logic       qtr_clk;
  logic       hlf_clk;
  logic       irq;

  int errors;
  int checks;

  frame_counter #(
    .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5), .CNT_W(5)
  ) dut (
    .apu_clk(apu_clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .irq_clr(irq_clr),
    .qtr_clk(qtr_clk),
    .hlf_clk(hlf_clk),
    .irq    (irq)
  );

  initial apu_clk = 1'b0;
  always #5 apu_clk = ~apu_clk;

  // Frame schedule: event positions per mode; the last one ends the frame.
  int qtrEvents4[$] = '{S1, S2, S3, S4};
  int hlfEvents4[$] = '{S2, S4};
  int qtrEvents5[$] = '{S1, S2, S3, S5};
  int hlfEvents5[$] = '{S2, S5};

  int   mPos;
  logic mFive;
  logic mInh;
  logic mIrq;
  logic mQ;
  logic mH;

  function automatic logic inList(input int v, input int lst[$]);
    foreach (lst[k]) if (lst[k] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelStep(input logic r, input logic w, input logic [7:0] d, input logic c);
    int frameLen;
    logic setIrq;
    if (r) begin
      mPos = 0; mFive = 1'b0; mInh = 1'b0; mIrq = 1'b0; mQ = 1'b0; mH = 1'b0;
    end else if (w) begin
      mFive = d[7];
      mInh  = d[6];
      mPos  = 0;
      mQ    = d[7];
      mH    = d[7];
      if (d[6] || c) mIrq = 1'b0;
    end else begin
      frameLen = mFive ? S5 + 1 : S4 + 1;
      mQ = mFive ? inList(mPos, qtrEvents5) : inList(mPos, qtrEvents4);
      mH = mFive ? inList(mPos, hlfEvents5) : inList(mPos, hlfEvents4);
      setIrq = !mFive && !mInh && (mPos == S4);
      if (setIrq) mIrq = 1'b1;
      else if (c) mIrq = 1'b0;
      mPos = (mPos + 1) % frameLen;
    end
  endtask

  task automatic checkOutput(input string name, input logic eq, input logic eh, input logic ei);
    checks++;
    if (qtr_clk !== eq || hlf_clk !== eh || irq !== ei) begin
      errors++;
      $display("[TB] FAIL %s: got qtr/hlf/irq=%b%b%b required %b%b%b at %0t",
               name, qtr_clk, hlf_clk, irq, eq, eh, ei, $time);
    end
    checks++;
    if (hlf_clk === 1'b1 && qtr_clk !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_hlf_alone: got hlf=%b qtr=%b required qtr=1", name, hlf_clk, qtr_clk);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] d, input logic c);
    rst = r; wr_en = w; wr_data = d; irq_clr = c;
    @(posedge apu_clk);
    #1;
    modelStep(r, w, d, c);
    checkOutput("model", mQ, mH, mIrq);
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; irq_clr = 1'b0;
  endtask

  typedef struct {
    int         idle;
    logic       r;
    logic       w;
    logic [7:0] d;
    logic       c;
    logic       eq;
    logic       eh;
    logic       ei;
  } vec_t;

  vec_t vecs[$];

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; irq_clr = 1'b0;
    mPos = 0; mFive = 1'b0; mInh = 1'b0; mIrq = 1'b0; mQ = 1'b0; mH = 1'b0;

    // idle cycles first, then one cycle with the listed inputs and expected outputs
    vecs.push_back('{0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // reset
    vecs.push_back('{3,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // cnt 3
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}); // STEP1 quarter
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // one cycle wide
    vecs.push_back('{2,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0}); // STEP2 q+h
    vecs.push_back('{6,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // cnt 15
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1}); // STEP4 set beats clr
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}); // clr next cycle
    vecs.push_back('{15, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}); // period wrap, irq again
    vecs.push_back('{0,  1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0}); // inhibit clears irq
    vecs.push_back('{16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0}); // STEP4, inhibited
    vecs.push_back('{0,  1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}); // 0x00 + clr
    vecs.push_back('{7,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // cnt 7
    vecs.push_back('{0,  1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // write at STEP2 suppresses
    vecs.push_back('{3,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // cnt 3
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}); // quarter STEP1 after restart
    vecs.push_back('{0,  1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0}); // 5-step write pulse pair
    vecs.push_back('{3,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // cnt 3
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}); // STEP1
    vecs.push_back('{10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // cnt 15
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // STEP4 silent in 5-step
    vecs.push_back('{2,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // cnt 19
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0}); // STEP5 q+h
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // wrapped to 0
    vecs.push_back('{2,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // reset at STEP1-1
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // no pulse after reset
    vecs.push_back('{2,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}); // cnt 3
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}); // 4-step STEP1
    vecs.push_back('{0,  1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 1'b1, 1'b0}); // back-to-back writes
    vecs.push_back('{0,  1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{0,  1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0}); // inhibit write at IRQ point
    vecs.push_back('{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].idle; k++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(vecs[i].r, vecs[i].w, vecs[i].d, vecs[i].c);
      checkOutput($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eh, vecs[i].ei);
    end

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 499) == 0,
                    $urandom_range(0, 149) == 0,
                    8'($urandom),
                    $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
